// File: rtl/ram_stream_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_stream_fifo_ctrl
// Description : Valid/ready FIFO controller wrapped around an external
//               dual-port RAM with 1-cycle registered read (FWFT output).
// Revision    : 1.0
// ============================================================================
module ram_stream_fifo_ctrl #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              s_valid,
    input  logic [3:0]        s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [3:0]        m_data,
    input  logic              m_ready,
    output logic              ram_write_en,
    output logic [7:0]        ram_write_addr,
    output logic [3:0]        ram_write_data,
    output logic              ram_read_en,
    output logic [7:0]        ram_read_addr,
    input  logic [3:0]        ram_read_data,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0]   c_DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_mem_count;
    logic              r_m_valid;

    logic              w_accept;
    logic              w_issue;

    // clr suppresses both RAM strobes so a flush cycle never touches the array
    assign w_accept = s_valid && !full && !clr;
    assign w_issue  = (r_mem_count != '0) && (!r_m_valid || m_ready) && !clr;

    assign full    = (r_mem_count == c_DEPTH);
    assign s_ready = !full;
    assign level   = r_mem_count + {{ADDR_W{1'b0}}, r_m_valid};
    assign empty   = (level == '0);

    assign m_valid = r_m_valid;
    assign m_data  = ram_read_data;

    assign ram_write_en   = w_accept;
    assign ram_write_addr = 8'(r_wr_ptr);
    assign ram_write_data = s_data;
    assign ram_read_en    = w_issue;
    assign ram_read_addr  = 8'(r_rd_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_count <= '0;
            r_m_valid   <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_count <= '0;
            r_m_valid   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_accept, w_issue})
                2'b10:   r_mem_count <= r_mem_count + c_CNT_ONE;
                2'b01:   r_mem_count <= r_mem_count - c_CNT_ONE;
                default: r_mem_count <= r_mem_count;
            endcase
            // a fresh issue refills the output slot even when it is being consumed
            if (w_issue) begin
                r_m_valid <= 1'b1;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_stream_fifo_ctrl
// Description : Directed self-checking bench for ram_stream_fifo_ctrl with a
//               behavioural 4-bit dual-port RAM attached.
// Revision    : 1.0
// ============================================================================
module tb_ram_stream_fifo_ctrl;

    localparam int ADDR_W = 7;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              s_valid;
    logic [3:0]        s_data;
    logic              s_ready;
    logic              m_valid;
    logic [3:0]        m_data;
    logic              m_ready;
    logic              ram_write_en;
    logic [7:0]        ram_write_addr;
    logic [3:0]        ram_write_data;
    logic              ram_read_en;
    logic [7:0]        ram_read_addr;
    logic [3:0]        ram_read_data;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              empty;

    ram_stream_fifo_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (clr),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .ram_write_en   (ram_write_en),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .ram_read_en    (ram_read_en),
        .ram_read_addr  (ram_read_addr),
        .ram_read_data  (ram_read_data),
        .level          (level),
        .full           (full),
        .empty          (empty)
    );

    // Storage array: 1-cycle registered read that holds while read enable is low
    logic [3:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_write_en) ram_mem[ram_write_addr] <= ram_write_data;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           ram_read_data <= 4'h0;
        else if (ram_read_en) ram_read_data <= ram_mem[ram_read_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc, first_mv, n_acc, n_ren, n_strobe;
    logic       last_wen, last_ren;
    logic [3:0] out_q[$];
    int         hs_cyc[$];

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [31:0] out_at(input int idx);
        if (idx < out_q.size()) return 32'(out_q[idx]);
        return 32'hDEAD;
    endfunction

    task automatic clear_log();
        cyc = 0; first_mv = -1; n_acc = 0; n_ren = 0; n_strobe = 0;
        out_q.delete();
        hs_cyc.delete();
    endtask

    // Called at a falling edge; drives inputs, logs this cycle, returns at next falling edge
    task automatic cycle(input logic sv, input logic [3:0] sd, input logic mr);
        s_valid = sv; s_data = sd; m_ready = mr;
        #1;
        last_wen = ram_write_en;
        last_ren = ram_read_en;
        if (ram_write_en || ram_read_en) n_strobe++;
        if (ram_read_en) n_ren++;
        if (s_valid && s_ready) n_acc++;
        if (m_valid && first_mv < 0) first_mv = cyc;
        if (m_valid && m_ready) begin
            out_q.push_back(m_data);
            hs_cyc.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbad;
        logic [3:0] exp5 [5];
        exp5 = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        rst_n = 1'b0; clr = 1'b0; s_valid = 1'b0; s_data = 4'h0; m_ready = 1'b0;
        clear_log();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_level",   32'(level),   0);
        check("rst_empty",   32'(empty),   1);
        check("rst_s_ready", 32'(s_ready), 1);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_full",    32'(full),    0);
        @(negedge clk);
        repeat (10) cycle(1'b0, 4'h0, 1'b0);
        check("idle_strobes", 32'(n_strobe), 0);
        check("idle_empty",   32'(empty),    1);

        // Back-to-back 1..8 with m_ready high
        clear_log();
        for (int i = 1; i <= 8; i++) cycle(1'b1, 4'(i), 1'b1);
        repeat (4) cycle(1'b0, 4'h0, 1'b1);
        check("b2b_latency", 32'(first_mv), 2);
        check("b2b_count",   32'(out_q.size()), 8);
        for (int k = 0; k < 8; k++) check($sformatf("b2b_word%0d", k), out_at(k), 32'(k + 1));
        check("b2b_consecutive", 32'(hs_cyc.size() == 8 ? hs_cyc[7] - hs_cyc[0] : -1), 7);

        // Fill to DEPTH+1 with m_ready low, then drain with wrap
        clear_log();
        for (int i = 0; i < 130; i++) cycle(1'b1, 4'(i), 1'b0);
        check("fill_accepts", 32'(n_acc),   129);
        check("fill_full",    32'(full),    1);
        check("fill_level",   32'(level),   129);
        check("fill_s_ready", 32'(s_ready), 0);
        check("fill_m_valid", 32'(m_valid), 1);
        repeat (135) cycle(1'b0, 4'h0, 1'b1);
        check("drain_count", 32'(out_q.size()), 129);
        nbad = 0;
        for (int k = 0; k < 129; k++) if (out_at(k) !== 32'(k % 16)) nbad++;
        check("drain_order",  32'(nbad), 0);
        check("drain_empty",  32'(empty), 1);
        check("drain_level",  32'(level), 0);
        check("wrap_wr_addr", 32'(ram_write_addr), 9);
        check("wrap_rd_addr", 32'(ram_read_addr),  9);

        // Output stall holds data and issues no reads
        clear_log();
        cycle(1'b1, 4'hA, 1'b0);
        cycle(1'b1, 4'hB, 1'b0);
        cycle(1'b0, 4'h0, 1'b0);
        check("stall_m_valid", 32'(m_valid), 1);
        check("stall_data0",   32'(m_data),  32'hA);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 4'h0, 1'b0);
            check($sformatf("stall_hold%0d", k), 32'(m_data), 32'hA);
        end
        check("stall_reads", 32'(n_ren), 1);
        repeat (4) cycle(1'b0, 4'h0, 1'b1);
        check("stall_count", 32'(out_q.size()), 2);
        check("stall_out0",  out_at(0), 32'hA);
        check("stall_out1",  out_at(1), 32'hB);

        // Simultaneous accept and issue with mem_count = 3
        clear_log();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0);
        check("sim_level_pre", 32'(level), 4);
        cycle(1'b1, 4'h5, 1'b1);
        check("sim_both_en",    32'({last_wen, last_ren}), 3);
        check("sim_level_post", 32'(level), 4);
        repeat (8) cycle(1'b0, 4'h0, 1'b1);
        check("sim_count", 32'(out_q.size()), 5);
        for (int k = 0; k < 5; k++) check($sformatf("sim_word%0d", k), out_at(k), 32'(exp5[k]));

        // Synchronous flush with level = 5
        clear_log();
        for (int i = 1; i <= 5; i++) cycle(1'b1, 4'(i), 1'b0);
        check("clr_level_pre", 32'(level), 5);
        clr = 1'b1;
        cycle(1'b1, 4'h7, 1'b1);
        clr = 1'b0;
        check("clr_strobes",  32'({last_wen, last_ren}), 0);
        check("clr_level",    32'(level),   0);
        check("clr_m_valid",  32'(m_valid), 0);
        clear_log();
        cycle(1'b1, 4'hC, 1'b1);
        repeat (4) cycle(1'b0, 4'h0, 1'b1);
        check("clr_next_count", 32'(out_q.size()), 1);
        check("clr_next_word",  out_at(0), 32'hC);

        // Asynchronous reset mid-stream
        clear_log();
        for (int i = 1; i <= 3; i++) cycle(1'b1, 4'(i + 4), 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_level",   32'(level),   0);
        check("arst_m_valid", 32'(m_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        cycle(1'b1, 4'hC, 1'b1);
        repeat (4) cycle(1'b0, 4'h0, 1'b1);
        check("arst_next_count", 32'(out_q.size()), 1);
        check("arst_next_word",  out_at(0), 32'hC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_stream_fifo_ctrl.md
# ram_stream_fifo_ctrl

Stream-to-RAM FIFO controller that sits directly in front of and behind the team's 4-bit synchronous dual-port RAM (8-bit addresses, 1-cycle registered read that holds its value while read enable is low). It accepts a valid/ready input stream and drives the RAM write port. It drives the RAM read port and presents the RAM read data as a first-word-fall-through valid/ready output stream. It owns all pointers, occupancy counting and flow control; the RAM stays a plain storage array.

## Interface
- ADDR_W, 7, RAM depth is DEPTH = 2^ADDR_W entries; must be ≤ 8
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush, active-high; priority over all stream activity
- s_valid  in  1  input word valid
- s_data  in  4  input word
- s_ready  out  1  controller can accept a word this cycle
- m_valid  out  1  output word valid
- m_data  out  4  output word; combinationally equal to ram_read_data
- m_ready  in  1  downstream accepts the output word
- ram_write_en  out  1  RAM write strobe
- ram_write_addr  out  8  RAM write address; bits above ADDR_W-1 are 0
- ram_write_data  out  4  RAM write data
- ram_read_en  out  1  RAM read strobe
- ram_read_addr  out  8  RAM read address; bits above ADDR_W-1 are 0
- ram_read_data  in  4  RAM registered read data
- level  out  ADDR_W+1  words held: mem_count + m_valid; range 0..DEPTH+1
- full  out  1  mem_count == DEPTH
- empty  out  1  level == 0

## Operation
- State registers: wr_ptr, rd_ptr (ADDR_W bits, natural wrap DEPTH-1 -> 0), mem_count (ADDR_W+1 bits, words in RAM not yet read out), m_valid.
- Reset values: wr_ptr = rd_ptr = 0, mem_count = 0, m_valid = 0. Resulting outputs: s_ready = 1, full = 0, empty = 1, level = 0, ram_write_en = 0, ram_read_en = 0. m_data follows the RAM's reset read value of 0.
- s_ready = !full. Accept = s_valid && s_ready.
- Write path (combinational): ram_write_en = accept; ram_write_addr = wr_ptr; ram_write_data = s_data. On accept, wr_ptr increments.
- Read issue (combinational): ram_read_en = (mem_count != 0) && (!m_valid || m_ready); ram_read_addr = rd_ptr. On issue, rd_ptr increments.
- m_valid next value: 1 if a read is issued. Otherwise 0 if m_valid && m_ready. Otherwise it holds.
- While m_valid && !m_ready, no read is issued. The RAM holds its output, so m_data stays stable.
- mem_count next value = mem_count + accept - read_issue. Simultaneous accept and issue leaves it unchanged.
- A read never targets a word written in the same cycle. Issue requires mem_count != 0, and mem_count counts only writes committed at earlier edges. There is no write/read address collision.
- Capacity is DEPTH+1 words: DEPTH in the RAM plus one presented at the output.
- clr = 1: at the next edge, pointers, mem_count and m_valid return to 0. ram_write_en and ram_read_en are forced 0 during the clr cycle. RAM contents are not cleared.
- Reset mid-operation returns all state to the reset values immediately. Any in-flight word is lost.

## Timing
- Input-to-output latency is 2 cycles. A word accepted at edge t is read-issued in cycle t+1 and shows m_valid = 1 after edge t+2, when the FIFO was empty before.
- Sustained throughput is 1 word/cycle in and out when m_ready = 1 and the FIFO is not empty.
- Output handshake completes on any edge with m_valid && m_ready. A back-to-back read is issued in that same cycle, so m_valid stays 1 with new data after the edge.
- s_ready deasserts in the cycle after the write that makes mem_count == DEPTH. It reasserts in the cycle after the first read issue from full.
- full, empty and level are derived combinationally from registered state and are glitch-free relative to clk.

## Test plan
- Reset then idle: level = 0, empty = 1, s_ready = 1, m_valid = 0, and no RAM strobes for 10 cycles.
- Write 0x1..0x8 back-to-back with m_ready = 1: m_valid rises 2 cycles after the first accept. Outputs are 0x1..0x8 on 8 consecutive cycles, in order.
- With m_ready = 0, write 129 words (ADDR_W = 7). full = 1 after 129 accepts, level = 129, s_ready = 0, and a 130th word is not accepted. Then drain: all 129 words come out in order, pointers wrap 127 -> 0, and the final state is empty = 1.
- Stall test: hold m_ready = 0 for 5 cycles while m_valid = 1 with data 0xA. m_data stays 0xA, ram_read_en = 0 throughout, and 0xA is consumed exactly once.
- Simultaneous accept and read issue at mem_count = 3: mem_count stays 3, and the data order is preserved.
- clr with level = 5, and separately rst_n pulsed low mid-stream: level = 0, m_valid = 0. The next written word 0xC is the first word output.
